// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, FSM
// states and datapath mux selects.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    A_RS1    = 2'b00,
    A_PC     = 2'b01,
    A_OLD_PC = 2'b10,
    A_ZERO   = 2'b11
  } alu_a_sel_t;

  typedef enum logic [1:0] {
    B_RS2   = 2'b00,
    B_IMM   = 2'b01,
    B_FOUR  = 2'b10
  } alu_b_sel_t;

  typedef enum logic [1:0] {
    PC_ALU      = 2'b00,
    PC_TARGET   = 2'b01,
    PC_ALU_ALGN = 2'b10
  } pc_sel_t;

  typedef enum logic [1:0] {
    WB_ALUOUT = 2'b00,
    WB_MEM    = 2'b01,
    WB_PC     = 2'b10
  } wb_sel_t;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Branch-taken decision from funct3 and the ALU flags of the rs1/rs2
// comparison.
module branch_resolve (
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       alu_lsb,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:         taken = alu_zero;
      3'b001:         taken = !alu_zero;
      3'b100, 3'b110: taken = alu_lsb;
      3'b101, 3'b111: taken = !alu_lsb;
      default:        taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main sequencing FSM of the multi-cycle RV32I core: time-shares one ALU and
// one memory port across fetch/decode/execute/memory/writeback.
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter int unsigned TIMEOUT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       alu_lsb,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_write,
  output logic       old_pc_write,
  output logic       pc_write,
  output logic [1:0] pc_sel,
  output logic       target_write,
  output logic [1:0] alu_a_sel,
  output logic [1:0] alu_b_sel,
  output logic       alu_force_add,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       illegal_insn,
  output logic       bus_error
);

  // The trap fires on the wait cycle that would make the count reach MEM_TIMEOUT.
  localparam logic [TIMEOUT_W-1:0] TO_LAST =
    TIMEOUT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t               state, state_nxt;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 taken;
  logic                 waiting;
  logic                 timeout_hit;
  logic                 set_illegal;
  logic                 set_bus;

  branch_resolve u_branch (
    .funct3   (funct3),
    .alu_zero (alu_zero),
    .alu_lsb  (alu_lsb),
    .taken    (taken)
  );

  assign waiting     = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
  assign timeout_hit = (MEM_TIMEOUT != 0) && waiting && (wait_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      illegal_insn <= 1'b0;
      bus_error    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (waiting && (MEM_TIMEOUT != 0)) wait_cnt <= wait_cnt + TIMEOUT_W'(1);
      else                               wait_cnt <= '0;
      if (set_illegal) illegal_insn <= 1'b1;
      if (set_bus)     bus_error    <= 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    set_illegal   = 1'b0;
    set_bus       = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;
    ir_write      = 1'b0;
    old_pc_write  = 1'b0;
    pc_write      = 1'b0;
    pc_sel        = PC_ALU;
    target_write  = 1'b0;
    alu_a_sel     = A_RS1;
    alu_b_sel     = B_RS2;
    alu_force_add = 1'b0;
    reg_write     = 1'b0;
    wb_sel        = WB_ALUOUT;

    case (state)
      S_IDLE: state_nxt = S_FETCH;

      S_FETCH: begin
        mem_req       = 1'b1;
        alu_a_sel     = A_PC;
        alu_b_sel     = B_FOUR;
        alu_force_add = 1'b1;
        if (mem_ready) begin
          ir_write     = 1'b1;
          old_pc_write = 1'b1;
          pc_write     = 1'b1;
          state_nxt    = S_DECODE;
        end else if (timeout_hit) begin
          set_bus   = 1'b1;
          state_nxt = S_TRAP;
        end
      end

      S_DECODE: begin
        alu_a_sel     = A_OLD_PC;
        alu_b_sel     = B_IMM;
        alu_force_add = 1'b1;
        target_write  = 1'b1;
        if (is_legal(opcode)) begin
          state_nxt = S_EXEC;
        end else begin
          set_illegal = 1'b1;
          state_nxt   = S_TRAP;
        end
      end

      S_EXEC: begin
        state_nxt = S_FETCH;
        case (opcode)
          OP_R:   state_nxt = S_WB;
          OP_IMM: begin
            alu_b_sel = B_IMM;
            state_nxt = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_b_sel     = B_IMM;
            alu_force_add = 1'b1;
            state_nxt     = S_MEM;
          end
          OP_BRANCH: begin
            if (taken) begin
              pc_write = 1'b1;
              pc_sel   = PC_TARGET;
            end
          end
          OP_JAL: begin
            pc_write  = 1'b1;
            pc_sel    = PC_TARGET;
            reg_write = 1'b1;
            wb_sel    = WB_PC;
          end
          OP_JALR: begin
            alu_b_sel     = B_IMM;
            alu_force_add = 1'b1;
            pc_write      = 1'b1;
            pc_sel        = PC_ALU_ALGN;
            reg_write     = 1'b1;
            wb_sel        = WB_PC;
          end
          OP_LUI: begin
            alu_a_sel     = A_ZERO;
            alu_b_sel     = B_IMM;
            alu_force_add = 1'b1;
            state_nxt     = S_WB;
          end
          OP_AUIPC: begin
            alu_a_sel     = A_OLD_PC;
            alu_b_sel     = B_IMM;
            alu_force_add = 1'b1;
            state_nxt     = S_WB;
          end
          default: state_nxt = S_FETCH;
        endcase
      end

      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (opcode == OP_STORE);
        if (mem_ready) begin
          state_nxt = (opcode == OP_LOAD) ? S_WB : S_FETCH;
        end else if (timeout_hit) begin
          set_bus   = 1'b1;
          state_nxt = S_TRAP;
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = (opcode == OP_LOAD) ? WB_MEM : WB_ALUOUT;
        state_nxt = S_FETCH;
      end

      S_TRAP:  state_nxt = S_TRAP;
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle control word checks for
// each instruction class, traps, timeout and asynchronous reset.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       alu_zero = 1'b0;
  logic       alu_lsb = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, mem_addr_sel, ir_write, old_pc_write, pc_write;
  logic [1:0] pc_sel, alu_a_sel, alu_b_sel, wb_sel;
  logic       target_write, alu_force_add, reg_write, illegal_insn, bus_error;
  logic [16:0] ctrl;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(3), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .alu_zero(alu_zero), .alu_lsb(alu_lsb), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_write(ir_write), .old_pc_write(old_pc_write), .pc_write(pc_write),
    .pc_sel(pc_sel), .target_write(target_write), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .alu_force_add(alu_force_add),
    .reg_write(reg_write), .wb_sel(wb_sel), .illegal_insn(illegal_insn),
    .bus_error(bus_error)
  );

  assign ctrl = {mem_req, mem_we, mem_addr_sel, ir_write, old_pc_write, pc_write,
                 pc_sel, target_write, alu_a_sel, alu_b_sel, alu_force_add,
                 reg_write, wb_sel};

  function automatic logic [16:0] ctl(
    input logic req, we, as, irw, opw, pcw, input logic [1:0] pcs,
    input logic tw, input logic [1:0] a, b, input logic fa, rw,
    input logic [1:0] wb);
    return {req, we, as, irw, opw, pcw, pcs, tw, a, b, fa, rw, wb};
  endfunction

  // Expected control words, built by hand from the state/opcode table.
  logic [16:0] F_WAIT, F_RDY, DEC, NONE, WB_ALU, WB_LD, EX_LS, MEM_LD, MEM_ST;
  logic [16:0] EX_I, EX_BR_T, EX_JAL, EX_JALR, EX_LUI, EX_AUIPC;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic rdy, input logic [16:0] exp);
    mem_ready = rdy;
    #1;
    check(tag, 32'(ctrl), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_ctrl", 32'(ctrl), 32'(NONE));
    check("rst_flags", {30'b0, illegal_insn, bus_error}, 32'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("idle", 1'b0, NONE);
  endtask

  task automatic set_insn(input logic [6:0] op, input logic [2:0] f3,
                          input logic z, input logic l);
    opcode = op; funct3 = f3; alu_zero = z; alu_lsb = l;
  endtask

  initial begin
    F_WAIT   = ctl(1,0,0,0,0,0,2'b00,0,2'b01,2'b10,1,0,2'b00);
    F_RDY    = ctl(1,0,0,1,1,1,2'b00,0,2'b01,2'b10,1,0,2'b00);
    DEC      = ctl(0,0,0,0,0,0,2'b00,1,2'b10,2'b01,1,0,2'b00);
    NONE     = '0;
    WB_ALU   = ctl(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,1,2'b00);
    WB_LD    = ctl(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,1,2'b01);
    EX_LS    = ctl(0,0,0,0,0,0,2'b00,0,2'b00,2'b01,1,0,2'b00);
    MEM_LD   = ctl(1,0,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,2'b00);
    MEM_ST   = ctl(1,1,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,2'b00);
    EX_I     = ctl(0,0,0,0,0,0,2'b00,0,2'b00,2'b01,0,0,2'b00);
    EX_BR_T  = ctl(0,0,0,0,0,1,2'b01,0,2'b00,2'b00,0,0,2'b00);
    EX_JAL   = ctl(0,0,0,0,0,1,2'b01,0,2'b00,2'b00,0,1,2'b10);
    EX_JALR  = ctl(0,0,0,0,0,1,2'b10,0,2'b00,2'b01,1,1,2'b10);
    EX_LUI   = ctl(0,0,0,0,0,0,2'b00,0,2'b11,2'b01,1,0,2'b00);
    EX_AUIPC = ctl(0,0,0,0,0,0,2'b00,0,2'b10,2'b01,1,0,2'b00);

    #1;
    do_reset();

    // ADD: 4 cycles, zero-wait memory
    set_insn(7'b0110011, 3'b000, 1'b0, 1'b0);
    step("add_f", 1, F_RDY); step("add_d", 1, DEC);
    step("add_e", 1, NONE);  step("add_w", 1, WB_ALU);

    // ADDI
    set_insn(7'b0010011, 3'b000, 1'b0, 1'b0);
    step("addi_f", 1, F_RDY); step("addi_d", 1, DEC);
    step("addi_e", 1, EX_I);  step("addi_w", 1, WB_ALU);

    // LW with two wait cycles in FETCH and in MEM: 9 cycles
    set_insn(7'b0000011, 3'b010, 1'b0, 1'b0);
    step("lw_f0", 0, F_WAIT); step("lw_f1", 0, F_WAIT); step("lw_f2", 1, F_RDY);
    step("lw_d", 1, DEC);     step("lw_e", 1, EX_LS);
    step("lw_m0", 0, MEM_LD); step("lw_m1", 0, MEM_LD); step("lw_m2", 1, MEM_LD);
    step("lw_w", 1, WB_LD);
    check("lw_no_buserr", {31'b0, bus_error}, 32'd0);

    // SW: 4 cycles
    set_insn(7'b0100011, 3'b010, 1'b0, 1'b0);
    step("sw_f", 1, F_RDY); step("sw_d", 1, DEC);
    step("sw_e", 1, EX_LS); step("sw_m", 1, MEM_ST);

    // Branches: 3 cycles each
    set_insn(7'b1100011, 3'b000, 1'b1, 1'b0);
    step("beq_t_f", 1, F_RDY); step("beq_t_d", 1, DEC); step("beq_t_e", 1, EX_BR_T);
    set_insn(7'b1100011, 3'b000, 1'b0, 1'b0);
    step("beq_n_f", 1, F_RDY); step("beq_n_d", 1, DEC); step("beq_n_e", 1, NONE);
    set_insn(7'b1100011, 3'b101, 1'b0, 1'b0);
    step("bge_f", 1, F_RDY);   step("bge_d", 1, DEC);   step("bge_e", 1, EX_BR_T);
    set_insn(7'b1100011, 3'b110, 1'b0, 1'b0);
    step("bltu_f", 1, F_RDY);  step("bltu_d", 1, DEC);  step("bltu_e", 1, NONE);
    set_insn(7'b1100011, 3'b001, 1'b1, 1'b0);
    step("bne_f", 1, F_RDY);   step("bne_d", 1, DEC);   step("bne_e", 1, NONE);

    // Jumps
    set_insn(7'b1101111, 3'b000, 1'b0, 1'b0);
    step("jal_f", 1, F_RDY);  step("jal_d", 1, DEC);  step("jal_e", 1, EX_JAL);
    set_insn(7'b1100111, 3'b000, 1'b0, 1'b0);
    step("jalr_f", 1, F_RDY); step("jalr_d", 1, DEC); step("jalr_e", 1, EX_JALR);

    // LUI / AUIPC
    set_insn(7'b0110111, 3'b000, 1'b0, 1'b0);
    step("lui_f", 1, F_RDY); step("lui_d", 1, DEC);
    step("lui_e", 1, EX_LUI); step("lui_w", 1, WB_ALU);
    set_insn(7'b0010111, 3'b000, 1'b0, 1'b0);
    step("auipc_f", 1, F_RDY); step("auipc_d", 1, DEC);
    step("auipc_e", 1, EX_AUIPC); step("auipc_w", 1, WB_ALU);

    // Illegal opcode traps and stays trapped until reset
    set_insn(7'b1111111, 3'b000, 1'b0, 1'b0);
    check("ill_pre", {31'b0, illegal_insn}, 32'd0);
    step("ill_f", 1, F_RDY); step("ill_d", 1, DEC);
    step("ill_t0", 1, NONE);
    check("ill_flag", {31'b0, illegal_insn}, 32'd1);
    step("ill_t1", 1, NONE); step("ill_t2", 1, NONE);
    check("ill_held", {31'b0, illegal_insn}, 32'd1);
    do_reset();
    set_insn(7'b0110011, 3'b000, 1'b0, 1'b0);
    step("post_ill_f", 1, F_RDY);
    step("post_ill_d", 1, DEC);
    check("ill_cleared", {31'b0, illegal_insn}, 32'd0);
    step("post_ill_e", 1, NONE); step("post_ill_w", 1, WB_ALU);

    // FETCH timeout with MEM_TIMEOUT=3
    step("to_f0", 0, F_WAIT); step("to_f1", 0, F_WAIT);
    check("to_pre", {31'b0, bus_error}, 32'd0);
    step("to_f2", 0, F_WAIT);
    step("to_trap0", 1, NONE);
    check("to_flag", {31'b0, bus_error}, 32'd1);
    step("to_trap1", 1, NONE);
    check("to_held", {31'b0, bus_error}, 32'd1);
    do_reset();

    // Asynchronous reset while a load waits in MEM
    set_insn(7'b0000011, 3'b010, 1'b0, 1'b0);
    step("ar_f", 1, F_RDY); step("ar_d", 1, DEC); step("ar_e", 1, EX_LS);
    mem_ready = 1'b0;
    #1;
    check("ar_mem", 32'(ctrl), 32'(MEM_LD));
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_abort", 32'(ctrl), 32'(NONE));
    @(posedge clk);
    #1;
    check("ar_held", 32'(ctrl), 32'(NONE));
    rst_n = 1'b1;
    step("ar_idle", 1, NONE);
    step("ar_refetch", 1, F_RDY);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main sequencing FSM for the multi-cycle RV32I core. A single ALU and a single memory port are time-shared across the fetch, decode, execute, memory and writeback phases.
- Drives the datapath mux selects, register write enables, memory handshake and the ALU "force ADD" override. The override takes priority over the opcode/funct-decoded ALU operation for PC/address arithmetic.
- Branch resolution uses ALU flags returned from the datapath.

Parameters:
- MEM_TIMEOUT, 0, number of cycles mem_req may wait for mem_ready before a bus error is raised; 0 disables the timeout.
- TIMEOUT_W, 8, width of the wait counter; MEM_TIMEOUT must be < 2**TIMEOUT_W.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instruction register [6:0]
- funct3  in  3  instruction register [14:12]
- alu_zero  in  1  ALU result == 0
- alu_lsb  in  1  ALU result bit 0 (SLT/SLTU outcome)
- mem_ready  in  1  memory accepts/completes current request
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write (store) request
- mem_addr_sel  out  1  0=PC, 1=ALU-out register
- ir_write  out  1  load instruction register
- old_pc_write  out  1  capture current PC into old_pc
- pc_write  out  1  load PC
- pc_sel  out  2  00=ALU result, 01=target reg, 10=ALU result & ~1
- target_write  out  1  load branch/jump target register
- alu_a_sel  out  2  00=rs1, 01=PC, 10=old_pc, 11=zero
- alu_b_sel  out  2  00=rs2, 01=imm, 10=constant 4
- alu_force_add  out  1  override decoded ALU op with ADD
- reg_write  out  1  register-file write enable
- wb_sel  out  2  00=ALU-out reg, 01=mem data, 10=PC
- illegal_insn  out  1  sticky: unsupported opcode trapped
- bus_error  out  1  sticky: memory timeout trapped

Behaviour:
- States:
  - IDLE (reset state, one cycle)
  - FETCH
  - DECODE
  - EXEC
  - MEM
  - WB
  - TRAP
- Reset:
  - Asynchronous, active-low.
  - State goes to IDLE; illegal_insn, bus_error and the wait counter clear.
  - In IDLE all outputs are 0.
  - Reset asserted mid-operation aborts immediately, including during a pending mem_req.
- Output timing: outputs are a combinational decode of state, opcode, funct3, flags and mem_ready. The state register is the only sequential logic besides the counter and sticky flags.
- IDLE: always goes to FETCH.
- FETCH:
  - Drives mem_req=1, mem_addr_sel=0, alu_a_sel=PC, alu_b_sel=4, alu_force_add=1.
  - In the mem_ready cycle it also drives ir_write, old_pc_write, pc_write (pc_sel=00), then goes to DECODE.
  - Otherwise it stays in FETCH.
- DECODE:
  - Drives alu_a_sel=old_pc, alu_b_sel=imm, alu_force_add=1, target_write=1.
  - Goes to EXEC for opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Any other opcode goes to TRAP and sets illegal_insn.
- EXEC, by opcode:
  - R-type: a=rs1, b=rs2, decoded op; then WB.
  - I-ALU: a=rs1, b=imm, decoded op; then WB.
  - Load/store: a=rs1, b=imm, force_add; then MEM.
  - Branch: a=rs1, b=rs2, decoded op.
    - Taken condition by funct3: 000 → zero; 001 → !zero; 100/110 → lsb; 101/111 → !lsb.
    - If taken: pc_write with pc_sel=01.
    - Then FETCH.
  - JAL: pc_write with pc_sel=01, plus reg_write with wb_sel=PC (the pre-update PC, i.e. old_pc+4); then FETCH.
  - JALR: a=rs1, b=imm, force_add, pc_write with pc_sel=10, reg_write with wb_sel=PC; then FETCH.
  - LUI: a=zero, b=imm, force_add; then WB.
  - AUIPC: a=old_pc, b=imm, force_add; then WB.
- MEM:
  - Drives mem_req=1, mem_addr_sel=1, mem_we=(opcode==0100011).
  - On mem_ready:
    - Load: goes to WB.
    - Store: goes to FETCH.
- WB:
  - Drives reg_write=1, with wb_sel=01 for loads and 00 otherwise; then FETCH.
- Memory timeout (MEM_TIMEOUT>0):
  - The counter increments each FETCH/MEM cycle with mem_ready=0 and clears on mem_ready or state exit.
  - When the count reaches MEM_TIMEOUT with mem_ready still low, the FSM goes to TRAP and sets bus_error.
  - mem_ready in the same cycle wins over the timeout.
- TRAP:
  - All outputs 0 except the sticky flags.
  - Stays in TRAP until reset.
- Cycle counts with zero-wait memory, including the FETCH cycle:
  - R/I/LUI/AUIPC: 4
  - Load: 5
  - Store: 4
  - Branch/JAL/JALR: 3
- Each extra memory wait cycle adds 1.

Decomposition:
- Package rv_ctrl_pkg holds:
  - opcode constants (shared with alu_control)
  - state encoding
  - the alu_a_sel, alu_b_sel, pc_sel and wb_sel encodings
- Optional sub-module: branch_resolve, a combinational block mapping funct3, alu_zero and alu_lsb to taken.

Test Plan:
- ADD (opcode 0110011), mem_ready always 1 → FETCH, DECODE, EXEC, WB over 4 cycles; reg_write=1 only in cycle 4 with wb_sel=00; pc_write only in cycle 1.
- LW with mem_ready delayed 2 cycles in both FETCH and MEM → 9 cycles total; mem_req held high throughout; wb_sel=01 in WB.
- BEQ with alu_zero=1 → pc_write=1, pc_sel=01 in EXEC; repeat with alu_zero=0 → no pc_write in EXEC; both take 3 cycles.
- BGE funct3=101 with alu_lsb=0 → taken; BLTU funct3=110 with alu_lsb=0 → not taken.
- Opcode 1111111 → TRAP after DECODE, illegal_insn=1 and held; rst_n pulse → IDLE, flag cleared, FETCH next cycle.
- MEM_TIMEOUT=3, mem_ready never asserted in FETCH → bus_error after 3 wait cycles; rst_n asserted mid-MEM → all outputs 0 immediately (asynchronous).
